mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Sequences one shared 32-bit memory port between two requesters: port 0 (instruction fetch) and port 1 (load/store).
- Arbitrates between them, latches the winner's address, write data and write-enable, and drives the select line of the 32-bit 2:1 address/data muxes in front of memory.
- Holds the grant until memory acknowledges, then returns read data with a one-cycle done pulse.
- Sits between the fetch/MEM pipeline stages and the unified memory.

Parameters:
- RR_MODE, 0, 0 = fixed priority (port 1 wins ties, with starvation guard); 1 = round-robin.
- STARVE_LIMIT, 4, fixed mode only: consecutive lost ties by port 0 before port 0 is forced to win; range 1..15.

Ports:
- clk  input  1  single system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- req0  input  1  port 0 request; held until done0 is sampled high.
- addr0  input  32  port 0 byte address.
- wdata0  input  32  port 0 write data.
- we0  input  1  port 0 write enable.
- req1  input  1  port 1 request; same rules as req0.
- addr1  input  32  port 1 byte address.
- wdata1  input  32  port 1 write data.
- we1  input  1  port 1 write enable.
- done0  output  1  one-cycle pulse: port 0 access complete.
- done1  output  1  one-cycle pulse: port 1 access complete.
- rdata  output  32  read data of the completed access; valid in the done cycle, held until the next completion.
- mem_req  output  1  memory access strobe.
- mem_we  output  1  memory write enable.
- mem_addr  output  32  memory address.
- mem_wdata  output  32  memory write data.
- mem_sel  output  1  mux select: 0 = port 0, 1 = port 1.
- mem_ack  input  1  memory completion; mem_rdata valid in the same cycle.
- mem_rdata  input  32  memory read data.
- busy  output  1  high in states GRANT and COMPLETE.

Behaviour:
- Reset:
  - state = IDLE.
  - mem_req, mem_we, done0, done1, busy, mem_sel = 0.
  - mem_addr, mem_wdata, rdata = 0.
  - last_grant = 1, so port 0 wins the first round-robin tie.
  - starve_cnt = 0.
  - rst high in any state aborts the access. No done pulse is issued, and the aborted requester must re-request.
- All outputs are registered.
- State IDLE:
  - No request: remain in IDLE.
  - Exactly one of req0/req1 high: grant that port.
  - Both high with RR_MODE=1: grant !last_grant.
  - Both high with RR_MODE=0: grant port 1, unless starve_cnt == STARVE_LIMIT, in which case grant port 0.
  - starve_cnt rule: +1 when a tie goes to port 1. Cleared whenever port 0 is granted.
  - On grant, at the next edge:
    - sel = grantee; last_grant = grantee.
    - Latch addr/wdata/we of the grantee into mem_addr/mem_wdata/mem_we.
    - mem_sel = grantee; mem_req = 1; state -> GRANT.
  - Latency: a request sampled at edge N gives mem_req high after edge N.
- State GRANT:
  - mem_req, mem_addr, mem_wdata, mem_we, mem_sel are held constant.
  - Requester inputs are ignored.
  - mem_ack = 0: stay in GRANT; there is no timeout.
  - mem_ack = 1 at edge M: rdata <= mem_rdata (captured for writes too), mem_req <= 0, mem_we <= 0, done[sel] <= 1, state -> COMPLETE.
- State COMPLETE:
  - Lasts exactly one cycle; done[sel] is high and no new grant is made.
  - Next edge: done <= 0, state -> IDLE.
  - Minimum occupancy is 3 cycles per access (GRANT, COMPLETE, IDLE), so back-to-back accesses are spaced 3 cycles apart when mem_ack arrives in the first GRANT cycle.
- Requester rule: drop req in the cycle after done is sampled. A req still high in IDLE is treated as a new request.
- mem_ack while in IDLE or COMPLETE: ignored, no state change.
- done0 and done1 are never high together.
- mem_sel changes only on IDLE->GRANT.

Test Plan:
- Single read: req0=1, addr0=0x0000_0040, mem_ack one cycle after mem_req with mem_rdata=0xDEAD_BEEF -> mem_sel=0, mem_addr=0x40, mem_we=0; done0 pulses for 1 cycle with rdata=0xDEAD_BEEF; done1 stays 0.
- Write with wait states: req1=1, we1=1, addr1=0x100, wdata1=0x1234_5678, mem_ack delayed 4 cycles -> mem_req is high for 5 cycles with stable addr/wdata and mem_we=1, mem_sel=1; one done1 pulse follows.
- Round-robin (RR_MODE=1): req0 and req1 held high continuously, each dropped for one cycle after its done -> grants alternate 0,1,0,1, with port 0 first after reset.
- Starvation guard (RR_MODE=0, STARVE_LIMIT=2): both requesting continuously -> grant order is 1,1,0,1,1,0.
- Mid-access reset: assert rst for 1 cycle while in GRANT -> next cycle mem_req=0, busy=0, no done pulse; the request is then re-granted from IDLE.
- Spurious ack: mem_ack=1 in IDLE with no requests -> no done, rdata unchanged, state stays IDLE.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// Bundle between the two requesters, the shared memory port and the arbiter.
// The arbiter uses the slave view; requesters/memory (or a bench) use the master view.
interface mem_port_arbiter_if;
  logic        req0;
  logic [31:0] addr0;
  logic [31:0] wdata0;
  logic        we0;
  logic        req1;
  logic [31:0] addr1;
  logic [31:0] wdata1;
  logic        we1;
  logic        done0;
  logic        done1;
  logic [31:0] rdata;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_sel;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        busy;

  modport slave (
    input  req0, addr0, wdata0, we0, req1, addr1, wdata1, we1, mem_ack, mem_rdata,
    output done0, done1, rdata, mem_req, mem_we, mem_addr, mem_wdata, mem_sel, busy
  );

  modport master (
    output req0, addr0, wdata0, we0, req1, addr1, wdata1, we1, mem_ack, mem_rdata,
    input  done0, done1, rdata, mem_req, mem_we, mem_addr, mem_wdata, mem_sel, busy
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Two-port arbiter for a single 32-bit memory port: fetch (port 0) vs load/store (port 1).
// Latches the winner's request, holds it until mem_ack, then pulses done with read data.
module mem_port_arbiter #(
  parameter int unsigned RR_MODE      = 0,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  mem_port_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    GRANT,
    COMPLETE
  } state_e;

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  state_e      state_q;
  logic        last_grant_q;
  logic [3:0]  starve_cnt_q;
  logic        mem_req_q;
  logic        mem_we_q;
  logic        mem_sel_q;
  logic        done0_q;
  logic        done1_q;
  logic        busy_q;
  logic [31:0] mem_addr_q;
  logic [31:0] mem_wdata_q;
  logic [31:0] rdata_q;

  logic        tie;
  logic        gnt_valid;
  logic        gnt_port;

  // Winner selection as seen in IDLE; only consumed in that state.
  always_comb begin
    tie       = bus.req0 & bus.req1;
    gnt_valid = bus.req0 | bus.req1;
    gnt_port  = 1'b0;
    if (tie) begin
      if (RR_MODE != 0) begin
        gnt_port = ~last_grant_q;
      end else begin
        gnt_port = (starve_cnt_q != LIMIT);
      end
    end else begin
      gnt_port = bus.req1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      starve_cnt_q <= '0;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_sel_q    <= 1'b0;
      done0_q      <= 1'b0;
      done1_q      <= 1'b0;
      busy_q       <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      rdata_q      <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (gnt_valid) begin
            state_q      <= GRANT;
            mem_req_q    <= 1'b1;
            busy_q       <= 1'b1;
            mem_sel_q    <= gnt_port;
            last_grant_q <= gnt_port;
            mem_addr_q   <= gnt_port ? bus.addr1  : bus.addr0;
            mem_wdata_q  <= gnt_port ? bus.wdata1 : bus.wdata0;
            mem_we_q     <= gnt_port ? bus.we1    : bus.we0;
            // Only ties handed to port 1 count as losses for port 0.
            if (!gnt_port) begin
              starve_cnt_q <= '0;
            end else if (tie && starve_cnt_q != 4'hF) begin
              starve_cnt_q <= starve_cnt_q + 4'd1;
            end
          end
        end
        GRANT: begin
          if (bus.mem_ack) begin
            state_q   <= COMPLETE;
            rdata_q   <= bus.mem_rdata;
            mem_req_q <= 1'b0;
            mem_we_q  <= 1'b0;
            done0_q   <= ~mem_sel_q;
            done1_q   <= mem_sel_q;
          end
        end
        COMPLETE: begin
          state_q <= IDLE;
          done0_q <= 1'b0;
          done1_q <= 1'b0;
          busy_q  <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.done0     = done0_q;
  assign bus.done1     = done1_q;
  assign bus.rdata     = rdata_q;
  assign bus.mem_req   = mem_req_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.mem_sel   = mem_sel_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench: a fixed-priority instance (STARVE_LIMIT=2) and a round-robin instance.
module tb_mem_port_arbiter;
  logic clk = 1'b0;
  logic rst_fx;
  logic rst_rr;
  int unsigned vec = 0;
  int unsigned bad = 0;

  always #5 clk = ~clk;

  mem_port_arbiter_if ifc_fx ();
  mem_port_arbiter_if ifc_rr ();

  mem_port_arbiter #(.RR_MODE(0), .STARVE_LIMIT(2)) dut_fx (.clk(clk), .rst(rst_fx), .bus(ifc_fx));
  mem_port_arbiter #(.RR_MODE(1), .STARVE_LIMIT(4)) dut_rr (.clk(clk), .rst(rst_rr), .bus(ifc_rr));

  task automatic init_inputs();
    ifc_fx.req0 = 0; ifc_fx.addr0 = '0; ifc_fx.wdata0 = '0; ifc_fx.we0 = 0;
    ifc_fx.req1 = 0; ifc_fx.addr1 = '0; ifc_fx.wdata1 = '0; ifc_fx.we1 = 0;
    ifc_fx.mem_ack = 0; ifc_fx.mem_rdata = '0;
    ifc_rr.req0 = 0; ifc_rr.addr0 = '0; ifc_rr.wdata0 = '0; ifc_rr.we0 = 0;
    ifc_rr.req1 = 0; ifc_rr.addr1 = '0; ifc_rr.wdata1 = '0; ifc_rr.we1 = 0;
    ifc_rr.mem_ack = 0; ifc_rr.mem_rdata = '0;
  endtask

  task automatic test_reset();
    rst_fx = 1; rst_rr = 1;
    ifc_fx.req0 = 1; ifc_fx.addr0 = 32'h1111_2222;
    repeat (2) @(negedge clk);
    vec++;
    if ({ifc_fx.mem_req, ifc_fx.mem_we, ifc_fx.mem_sel, ifc_fx.done0, ifc_fx.done1, ifc_fx.busy} !== 6'b0) begin
      bad++; $display("FAIL reset_ctrl_fx: got %b expected 000000",
        {ifc_fx.mem_req, ifc_fx.mem_we, ifc_fx.mem_sel, ifc_fx.done0, ifc_fx.done1, ifc_fx.busy});
    end
    vec++;
    if ({ifc_fx.mem_addr, ifc_fx.mem_wdata, ifc_fx.rdata} !== 96'h0) begin
      bad++; $display("FAIL reset_data_fx: got %h %h %h expected all zero",
        ifc_fx.mem_addr, ifc_fx.mem_wdata, ifc_fx.rdata);
    end
    vec++;
    if ({ifc_rr.mem_req, ifc_rr.mem_we, ifc_rr.mem_sel, ifc_rr.done0, ifc_rr.done1, ifc_rr.busy,
         ifc_rr.mem_addr, ifc_rr.mem_wdata, ifc_rr.rdata} !== 102'h0) begin
      bad++; $display("FAIL reset_rr: got nonzero outputs, expected all zero");
    end
    ifc_fx.req0 = 0; ifc_fx.addr0 = '0;
    rst_fx = 0; rst_rr = 0;
    @(negedge clk);
    vec++;
    if (ifc_fx.mem_req !== 1'b0 || ifc_fx.busy !== 1'b0) begin
      bad++; $display("FAIL reset_idle: got req=%b busy=%b expected 0 0", ifc_fx.mem_req, ifc_fx.busy);
    end
  endtask

  task automatic test_single_read();
    ifc_fx.req0 = 1; ifc_fx.addr0 = 32'h0000_0040; ifc_fx.we0 = 0; ifc_fx.wdata0 = 32'h5555_AAAA;
    @(negedge clk);
    vec++;
    if (ifc_fx.mem_req !== 1 || ifc_fx.mem_sel !== 0 || ifc_fx.mem_we !== 0 || ifc_fx.busy !== 1) begin
      bad++; $display("FAIL read_grant: got req=%b sel=%b we=%b busy=%b expected 1 0 0 1",
        ifc_fx.mem_req, ifc_fx.mem_sel, ifc_fx.mem_we, ifc_fx.busy);
    end
    vec++;
    if (ifc_fx.mem_addr !== 32'h0000_0040) begin
      bad++; $display("FAIL read_addr: got %h expected 00000040", ifc_fx.mem_addr);
    end
    ifc_fx.mem_ack = 1; ifc_fx.mem_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    vec++;
    if (ifc_fx.done0 !== 1 || ifc_fx.done1 !== 0 || ifc_fx.mem_req !== 0) begin
      bad++; $display("FAIL read_done: got done0=%b done1=%b req=%b expected 1 0 0",
        ifc_fx.done0, ifc_fx.done1, ifc_fx.mem_req);
    end
    vec++;
    if (ifc_fx.rdata !== 32'hDEAD_BEEF) begin
      bad++; $display("FAIL read_rdata: got %h expected deadbeef", ifc_fx.rdata);
    end
    ifc_fx.req0 = 0; ifc_fx.mem_ack = 0; ifc_fx.mem_rdata = '0;
    @(negedge clk);
    vec++;
    if (ifc_fx.done0 !== 0 || ifc_fx.busy !== 0 || ifc_fx.rdata !== 32'hDEAD_BEEF) begin
      bad++; $display("FAIL read_after: got done0=%b busy=%b rdata=%h expected 0 0 deadbeef",
        ifc_fx.done0, ifc_fx.busy, ifc_fx.rdata);
    end
    @(negedge clk);
    vec++;
    if (ifc_fx.mem_req !== 0) begin
      bad++; $display("FAIL read_no_regrant: got mem_req=%b expected 0", ifc_fx.mem_req);
    end
  endtask

  task automatic test_write_wait();
    ifc_fx.req1 = 1; ifc_fx.we1 = 1; ifc_fx.addr1 = 32'h0000_0100; ifc_fx.wdata1 = 32'h1234_5678;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      vec++;
      if (ifc_fx.mem_req !== 1 || ifc_fx.mem_we !== 1 || ifc_fx.mem_sel !== 1 ||
          ifc_fx.mem_addr !== 32'h0000_0100 || ifc_fx.mem_wdata !== 32'h1234_5678 ||
          ifc_fx.done1 !== 0) begin
        bad++; $display("FAIL write_hold[%0d]: got req=%b we=%b sel=%b addr=%h wdata=%h done1=%b expected 1 1 1 00000100 12345678 0",
          i, ifc_fx.mem_req, ifc_fx.mem_we, ifc_fx.mem_sel, ifc_fx.mem_addr, ifc_fx.mem_wdata, ifc_fx.done1);
      end
      if (i == 1) begin
        ifc_fx.addr1 = 32'hFFFF_0000; ifc_fx.wdata1 = 32'h0;
      end
      if (i == 4) begin
        ifc_fx.mem_ack = 1; ifc_fx.mem_rdata = 32'hCAFE_0001;
      end
    end
    @(negedge clk);
    vec++;
    if (ifc_fx.done1 !== 1 || ifc_fx.done0 !== 0 || ifc_fx.mem_req !== 0 || ifc_fx.mem_we !== 0 ||
        ifc_fx.mem_sel !== 1 || ifc_fx.rdata !== 32'hCAFE_0001) begin
      bad++; $display("FAIL write_done: got done1=%b done0=%b req=%b we=%b sel=%b rdata=%h expected 1 0 0 0 1 cafe0001",
        ifc_fx.done1, ifc_fx.done0, ifc_fx.mem_req, ifc_fx.mem_we, ifc_fx.mem_sel, ifc_fx.rdata);
    end
    ifc_fx.req1 = 0; ifc_fx.we1 = 0; ifc_fx.mem_ack = 0;
    @(negedge clk);
    vec++;
    if (ifc_fx.done1 !== 0 || ifc_fx.mem_sel !== 1 || ifc_fx.busy !== 0) begin
      bad++; $display("FAIL write_after: got done1=%b sel=%b busy=%b expected 0 1 0",
        ifc_fx.done1, ifc_fx.mem_sel, ifc_fx.busy);
    end
  endtask

  task automatic test_spurious_ack();
    ifc_fx.mem_ack = 1; ifc_fx.mem_rdata = 32'hFFFF_FFFF;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      vec++;
      if (ifc_fx.done0 !== 0 || ifc_fx.done1 !== 0 || ifc_fx.busy !== 0 || ifc_fx.mem_req !== 0 ||
          ifc_fx.rdata !== 32'hCAFE_0001) begin
        bad++; $display("FAIL spurious_ack[%0d]: got done=%b%b busy=%b req=%b rdata=%h expected 00 0 0 cafe0001",
          i, ifc_fx.done0, ifc_fx.done1, ifc_fx.busy, ifc_fx.mem_req, ifc_fx.rdata);
      end
    end
    ifc_fx.mem_ack = 0; ifc_fx.mem_rdata = '0;
  endtask

  task automatic test_mid_reset();
    ifc_fx.req0 = 1; ifc_fx.addr0 = 32'h0000_0080; ifc_fx.we0 = 0;
    @(negedge clk);
    vec++;
    if (ifc_fx.mem_req !== 1 || ifc_fx.busy !== 1) begin
      bad++; $display("FAIL midrst_grant: got req=%b busy=%b expected 1 1", ifc_fx.mem_req, ifc_fx.busy);
    end
    rst_fx = 1;
    @(negedge clk);
    rst_fx = 0;
    vec++;
    if (ifc_fx.mem_req !== 0 || ifc_fx.busy !== 0 || ifc_fx.done0 !== 0 || ifc_fx.rdata !== 32'h0) begin
      bad++; $display("FAIL midrst_abort: got req=%b busy=%b done0=%b rdata=%h expected 0 0 0 00000000",
        ifc_fx.mem_req, ifc_fx.busy, ifc_fx.done0, ifc_fx.rdata);
    end
    @(negedge clk);
    vec++;
    if (ifc_fx.mem_req !== 1 || ifc_fx.mem_addr !== 32'h0000_0080 || ifc_fx.done0 !== 0) begin
      bad++; $display("FAIL midrst_regrant: got req=%b addr=%h done0=%b expected 1 00000080 0",
        ifc_fx.mem_req, ifc_fx.mem_addr, ifc_fx.done0);
    end
    ifc_fx.mem_ack = 1; ifc_fx.mem_rdata = 32'h0BAD_F00D;
    @(negedge clk);
    vec++;
    if (ifc_fx.done0 !== 1 || ifc_fx.rdata !== 32'h0BAD_F00D) begin
      bad++; $display("FAIL midrst_done: got done0=%b rdata=%h expected 1 0badf00d", ifc_fx.done0, ifc_fx.rdata);
    end
    ifc_fx.req0 = 0; ifc_fx.mem_ack = 0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_round_robin();
    bit [0:5] exp_order = 6'b010101;
    int n = 0;
    ifc_rr.addr0 = 32'h0000_0200; ifc_rr.addr1 = 32'h0000_0300;
    for (int cyc = 0; cyc < 100 && n < 6; cyc++) begin
      @(negedge clk);
      vec++;
      if (ifc_rr.done0 === 1 && ifc_rr.done1 === 1) begin
        bad++; $display("FAIL rr_done_both: got done0=1 done1=1 expected not both");
      end
      ifc_rr.mem_ack = 0;
      ifc_rr.req0 = !ifc_rr.done0;
      ifc_rr.req1 = !ifc_rr.done1;
      if (ifc_rr.mem_req === 1) begin
        vec++;
        if (ifc_rr.mem_sel !== exp_order[n]) begin
          bad++; $display("FAIL rr_grant[%0d]: got %b expected %b", n, ifc_rr.mem_sel, exp_order[n]);
        end
        n++;
        ifc_rr.mem_ack = 1;
      end
    end
    vec++;
    if (n != 6) begin
      bad++; $display("FAIL rr_timeout: got %0d grants expected 6", n);
    end
    @(negedge clk);
    ifc_rr.req0 = 0; ifc_rr.req1 = 0; ifc_rr.mem_ack = 0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_starvation();
    bit [0:5] exp_order = 6'b110110;
    int n = 0;
    ifc_fx.addr0 = 32'h0000_0200; ifc_fx.addr1 = 32'h0000_0300;
    ifc_fx.we0 = 0; ifc_fx.we1 = 0;
    for (int cyc = 0; cyc < 100 && n < 6; cyc++) begin
      @(negedge clk);
      vec++;
      if (ifc_fx.done0 === 1 && ifc_fx.done1 === 1) begin
        bad++; $display("FAIL fx_done_both: got done0=1 done1=1 expected not both");
      end
      ifc_fx.mem_ack = 0;
      ifc_fx.req0 = !ifc_fx.done0;
      ifc_fx.req1 = !ifc_fx.done1;
      if (ifc_fx.mem_req === 1) begin
        vec++;
        if (ifc_fx.mem_sel !== exp_order[n]) begin
          bad++; $display("FAIL starve_grant[%0d]: got %b expected %b", n, ifc_fx.mem_sel, exp_order[n]);
        end
        n++;
        ifc_fx.mem_ack = 1;
      end
    end
    vec++;
    if (n != 6) begin
      bad++; $display("FAIL starve_timeout: got %0d grants expected 6", n);
    end
    @(negedge clk);
    ifc_fx.req0 = 0; ifc_fx.req1 = 0; ifc_fx.mem_ack = 0;
    repeat (3) @(negedge clk);
    vec++;
    if (ifc_fx.busy !== 0 || ifc_fx.mem_req !== 0) begin
      bad++; $display("FAIL starve_drain: got busy=%b req=%b expected 0 0", ifc_fx.busy, ifc_fx.mem_req);
    end
  endtask

  initial begin
    init_inputs();
    test_reset();
    test_single_read();
    test_write_wait();
    test_spurious_ack();
    test_mid_reset();
    test_round_robin();
    test_starvation();
    $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
    $finish;
  end
endmodule
